alu_arbiter: RTL and testbench

//  Shares one registered 16-bit ALU (add / sub / mul, 2-bit op, registered result and zero flag)

---
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one registered ALU between N_REQ requesters.
// Each operation runs IDLE -> ISSUE -> WAIT (LAT cycles) -> DONE with all outputs registered.
module alu_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 16,
    parameter int LAT   = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ*W-1:0] i_in1,
    input  logic [N_REQ*W-1:0] i_in2,
    input  logic [N_REQ*2-1:0] i_op,
    output logic [N_REQ-1:0]   o_grant,
    output logic [N_REQ-1:0]   o_done,
    output logic [W-1:0]       o_result,
    output logic               o_z,
    output logic               o_busy,
    output logic [W-1:0]       o_alu_in1,
    output logic [W-1:0]       o_alu_in2,
    output logic [1:0]         o_alu_op,
    input  logic [W-1:0]       i_alu_out,
    input  logic               i_alu_z
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     ptr_q;
    logic [CW-1:0]     cnt_q;
    logic [N_REQ-1:0]  grant_q;
    logic [N_REQ-1:0]  done_q;
    logic [W-1:0]      result_q;
    logic              z_q;
    logic              busy_q;
    logic [W-1:0]      alu_in1_q;
    logic [W-1:0]      alu_in2_q;
    logic [1:0]        alu_op_q;
    logic [1:0]        op_q;

    logic [W-1:0]      in1_arr [N_REQ];
    logic [W-1:0]      in2_arr [N_REQ];
    logic [1:0]        op_arr  [N_REQ];

    logic              win_found_d;
    logic [PW-1:0]     win_idx_d;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign in1_arr[gi] = i_in1[gi*W +: W];
            assign in2_arr[gi] = i_in2[gi*W +: W];
            assign op_arr[gi]  = i_op[gi*2 +: 2];
        end
    endgenerate

    // Scan from the highest rotation offset down so the last hit is the
    // first requester found searching upward from ptr_q+1.
    always_comb begin
        logic [PW-1:0] idx;
        win_found_d = 1'b0;
        win_idx_d   = '0;
        idx         = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr_q) + 1 + i) % N_REQ);
            if (i_req[idx]) begin
                win_found_d = 1'b1;
                win_idx_d   = idx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            ptr_q     <= PW'(N_REQ - 1);
            cnt_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            result_q  <= '0;
            z_q       <= 1'b0;
            busy_q    <= 1'b0;
            alu_in1_q <= '0;
            alu_in2_q <= '0;
            alu_op_q  <= 2'd0;
            op_q      <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        grant_q   <= N_REQ'(1) << win_idx_d;
                        alu_in1_q <= in1_arr[win_idx_d];
                        alu_in2_q <= in2_arr[win_idx_d];
                        op_q      <= op_arr[win_idx_d];
                        alu_op_q  <= op_arr[win_idx_d];
                        ptr_q     <= win_idx_d;
                        busy_q    <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    alu_op_q <= 2'd0;
                    cnt_q    <= CW'(LAT - 1);
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        result_q <= i_alu_out;
                        z_q      <= i_alu_z;
                        done_q   <= grant_q;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    done_q  <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_grant   = grant_q;
    assign o_done    = done_q;
    assign o_result  = result_q;
    assign o_z       = z_q;
    assign o_busy    = busy_q;
    assign o_alu_in1 = alu_in1_q;
    assign o_alu_in2 = alu_in2_q;
    assign o_alu_op  = alu_op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a two-stage registered ALU model behind it.
module tb_alu_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int LAT = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   in1;
    logic [N*W-1:0]   in2;
    logic [N*2-1:0]   op;
    logic [N-1:0]     grant;
    logic [N-1:0]     done;
    logic [W-1:0]     result;
    logic             z;
    logic             busy;
    logic [W-1:0]     alu_in1;
    logic [W-1:0]     alu_in2;
    logic [1:0]       alu_op;
    logic [W-1:0]     alu_out;
    logic             alu_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N_REQ(N), .W(W), .LAT(LAT)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_in1     (in1),
        .i_in2     (in2),
        .i_op      (op),
        .o_grant   (grant),
        .o_done    (done),
        .o_result  (result),
        .o_z       (z),
        .o_busy    (busy),
        .o_alu_in1 (alu_in1),
        .o_alu_in2 (alu_in2),
        .o_alu_op  (alu_op),
        .i_alu_out (alu_out),
        .i_alu_z   (alu_z)
    );

    // Shared ALU: op 0 holds stage 1, so the output repeats the previous result.
    logic [W-1:0] s1_q = '0;
    logic [W-1:0] s2_q = '0;
    logic         s1z_q = 1'b1;
    logic         s2z_q = 1'b1;
    logic [W-1:0] alu_f;

    always_comb begin
        alu_f = '0;
        case (alu_op)
            2'd1: alu_f = alu_in1 + alu_in2;
            2'd2: alu_f = alu_in2 - alu_in1;
            2'd3: alu_f = W'(alu_in1 * alu_in2);
            default: alu_f = s1_q;
        endcase
    end

    always @(posedge clk) begin
        if (alu_op != 2'd0) begin
            s1_q  <= alu_f;
            s1z_q <= (alu_f == '0);
        end
        s2_q  <= s1_q;
        s2z_q <= s1z_q;
    end

    assign alu_out = s2_q;
    assign alu_z   = s2z_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        req[k]        = 1'b1;
        in1[k*W +: W] = a;
        in2[k*W +: W] = b;
        op[k*2 +: 2]  = o;
    endtask

    // Counts negedges until o_done is seen (bounded); the count is returned.
    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done == '0 && cyc < 20);
        check({tag, "_done_seen"}, 32'(done != '0), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_op(input string tag, input int k, input logic [1:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_r, input logic exp_z);
        int cyc;
        set_req(k, o, a, b);
        @(negedge clk);
        check({tag, "_grant"}, 32'(grant), 32'(1 << k));
        check({tag, "_issue_op"}, 32'(alu_op), 32'(o));
        check({tag, "_issue_in1"}, 32'(alu_in1), 32'(a));
        @(negedge clk);
        check({tag, "_wait_op"}, 32'(alu_op), 32'd0);
        check({tag, "_wait_nodone"}, 32'(done), 32'd0);
        wait_done(tag, cyc);
        check({tag, "_latency"}, 32'(cyc), 32'd2);
        check({tag, "_done"}, 32'(done), 32'(1 << k));
        check({tag, "_result"}, 32'(result), 32'(exp_r));
        check({tag, "_z"}, 32'(z), 32'(exp_z));
        $display("op %s req%0d op=%0d in1=%0d in2=%0d result=%0d z=%0d", tag, k, o, a, b, result, z);
        req[k] = 1'b0;
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_grant"}, 32'(grant), 32'd0);
    endtask

    initial begin
        int cyc;
        int seq [7];
        seq = '{0, 2, 0, 2, 0, 1, 2};
        rst = 1'b1;
        req = '0;
        in1 = '0;
        in2 = '0;
        op  = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_z", 32'(z), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_in1", 32'(alu_in1), 32'd0);
        check("rst_alu_in2", 32'(alu_in2), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        @(negedge clk);
        check("idle_noreq_busy", 32'(busy), 32'd0);

        run_op("add_3_4", 0, 2'd1, 16'd3, 16'd4, 16'd7, 1'b0);
        run_op("sub_5_5", 1, 2'd2, 16'd5, 16'd5, 16'd0, 1'b1);
        run_op("sub_2_9", 1, 2'd2, 16'd2, 16'd9, 16'd7, 1'b0);
        run_op("sub_wrap", 1, 2'd2, 16'd9, 16'd2, 16'd65529, 1'b0);
        run_op("add_wrap", 2, 2'd1, 16'hFFFF, 16'd1, 16'd0, 1'b1);
        run_op("mul_300", 3, 2'd3, 16'd300, 16'd300, 16'd24464, 1'b0);
        run_op("op0_hold", 3, 2'd0, 16'd7, 16'd7, 16'd24464, 1'b0);

        // Round-robin with req0/req2 held, then req1 joins.
        do_reset();
        set_req(0, 2'd1, 16'd1, 16'd2);
        set_req(2, 2'd1, 16'd10, 16'd20);
        for (int i = 0; i < 7; i++) begin
            if (i == 4) set_req(1, 2'd3, 16'd3, 16'd4);
            wait_done("rr", cyc);
            check($sformatf("rr%0d_grant", i), 32'(done), 32'(1 << seq[i]));
            check($sformatf("rr%0d_spacing", i), 32'(cyc), (i == 0) ? 32'd4 : 32'(LAT + 3));
            check($sformatf("rr%0d_result", i), 32'(result),
                  (seq[i] == 0) ? 32'd3 : (seq[i] == 1) ? 32'd12 : 32'd30);
            $display("op rr%0d done=%b result=%0d", i, done, result);
        end
        req = '0;
        @(negedge clk);
        check("rr_end_busy", 32'(busy), 32'd0);

        // Reset during WAIT discards the op; the held request is served afresh.
        set_req(0, 2'd1, 16'd1, 16'd1);
        @(negedge clk);
        @(negedge clk);
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_alu_op", 32'(alu_op), 32'd0);
        check("midrst_alu_in1", 32'(alu_in1), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_z", 32'(z), 32'd0);
        wait_done("reissue", cyc);
        check("reissue_latency", 32'(cyc), 32'd4);
        check("reissue_done", 32'(done), 32'd1);
        check("reissue_result", 32'(result), 32'd2);
        $display("op reissue done=%b result=%0d", done, result);
        req = '0;
        @(negedge clk);

        // Requester drops i_req and changes operands after the grant.
        set_req(2, 2'd1, 16'd10, 16'd20);
        @(negedge clk);
        check("drop_grant", 32'(grant), 32'd4);
        req[2]        = 1'b0;
        in1[2*W +: W] = 16'd100;
        wait_done("drop", cyc);
        check("drop_latency", 32'(cyc), 32'd3);
        check("drop_done", 32'(done), 32'd4);
        check("drop_result", 32'(result), 32'd30);
        $display("op drop done=%b result=%0d", done, result);
        @(negedge clk);
        check("drop_idle_grant", 32'(grant), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
